// File: rtl/rfsoc_dac_player.sv
// Multi-channel DAC waveform player: per-channel load/arm/play with shared load stream and trigger.
// Optional feature: define RFSOC_DAC_PLAYER_LOOP_EN to add the loop_mode input (continuous replay).
module rfsoc_dac_player #(
   parameter  int NUM_CH = 16,
   parameter  int DATA_W = 256,
   parameter  int DEPTH  = 64,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     pl_clk,
   input  logic                     rst,
   input  logic [CH_W-1:0]          chan_sel,
   input  logic                     load_start,
   input  logic                     stop,
   input  logic                     trigger,
`ifdef RFSOC_DAC_PLAYER_LOOP_EN
   input  logic                     loop_mode,
`endif
   input  logic [DATA_W-1:0]        s_axis_tdata,
   input  logic                     s_axis_tvalid,
   input  logic                     s_axis_tlast,
   output logic                     s_axis_tready,
   output logic [NUM_CH*DATA_W-1:0] m_axis_tdata,
   output logic [NUM_CH-1:0]        m_axis_tvalid,
   input  logic [NUM_CH-1:0]        m_axis_tready,
   output logic [NUM_CH-1:0]        ch_armed,
   output logic [NUM_CH-1:0]        ch_busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LEN_W = PTR_W + 1;

   typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_ARMED, S_PLAY} state_e;

   state_e            r_state      [NUM_CH];
   state_e            w_state_nxt  [NUM_CH];
   logic [PTR_W-1:0]  r_wr_ptr     [NUM_CH];
   logic [PTR_W-1:0]  w_wr_ptr_nxt [NUM_CH];
   logic [PTR_W-1:0]  r_rd_ptr     [NUM_CH];
   logic [PTR_W-1:0]  w_rd_ptr_nxt [NUM_CH];
   logic [LEN_W-1:0]  r_len        [NUM_CH];
   logic [LEN_W-1:0]  w_len_nxt    [NUM_CH];
   logic [DATA_W-1:0] r_mem        [NUM_CH][DEPTH];

   logic [CH_W-1:0]   r_load_ch;
   logic              r_trigger_q;
   logic [NUM_CH-1:0] r_ch_armed;
   logic [NUM_CH-1:0] r_ch_busy;

   logic              w_loop;
   logic              w_sel_ok;
   logic              w_load;
   logic              w_trig_go;
   logic              w_s_fire;
   logic              w_load_ch_in_load;
   logic [NUM_CH-1:0] w_m_valid;

`ifdef RFSOC_DAC_PLAYER_LOOP_EN
   assign w_loop = loop_mode;
`else
   assign w_loop = 1'b0;
`endif

   // When NUM_CH fills the select field every code is a real channel.
   generate
      if (NUM_CH == (1 << CH_W)) begin : g_sel_full
         assign w_sel_ok = 1'b1;
      end else begin : g_sel_part
         assign w_sel_ok = (chan_sel < CH_W'(NUM_CH));
      end
   endgenerate

   assign w_load    = load_start & w_sel_ok;
   // A stop in the same cycle swallows the trigger edge for every channel.
   assign w_trig_go = trigger & ~r_trigger_q & ~stop;
   assign w_s_fire  = s_axis_tvalid & s_axis_tready;

   always_ff @(posedge pl_clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_state[i]  <= S_EMPTY;
            r_wr_ptr[i] <= '0;
            r_rd_ptr[i] <= '0;
            r_len[i]    <= '0;
         end
         r_load_ch   <= '0;
         r_trigger_q <= 1'b1;
         r_ch_armed  <= '0;
         r_ch_busy   <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_state[i]    <= w_state_nxt[i];
            r_wr_ptr[i]   <= w_wr_ptr_nxt[i];
            r_rd_ptr[i]   <= w_rd_ptr_nxt[i];
            r_len[i]      <= w_len_nxt[i];
            r_ch_armed[i] <= (w_state_nxt[i] == S_ARMED);
            r_ch_busy[i]  <= (w_state_nxt[i] == S_PLAY);
         end
         r_trigger_q <= trigger;
         if (w_load) r_load_ch <= chan_sel;
      end
   end

   // NOTE: waveform storage is deliberately left out of reset so it maps onto plain RAM.
   always_ff @(posedge pl_clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_s_fire && r_load_ch == CH_W'(i)) r_mem[i][r_wr_ptr[i]] <= s_axis_tdata;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         // NOTE: every next-state value is defaulted to its register so no path infers a latch.
         w_state_nxt[i]  = r_state[i];
         w_wr_ptr_nxt[i] = r_wr_ptr[i];
         w_rd_ptr_nxt[i] = r_rd_ptr[i];
         w_len_nxt[i]    = r_len[i];
         if (w_load && chan_sel == CH_W'(i)) begin
            w_state_nxt[i]  = S_LOAD;
            w_wr_ptr_nxt[i] = '0;
         end else if (w_load && r_state[i] == S_LOAD) begin
            w_len_nxt[i]   = LEN_W'(r_wr_ptr[i]);
            w_state_nxt[i] = (r_wr_ptr[i] == '0) ? S_EMPTY : S_ARMED;
         end else if (stop && r_state[i] == S_PLAY) begin
            w_state_nxt[i] = S_ARMED;
         end else if (w_trig_go && r_state[i] == S_ARMED) begin
            w_state_nxt[i]  = S_PLAY;
            w_rd_ptr_nxt[i] = '0;
         end else begin
            case (r_state[i])
               S_LOAD: begin
                  if (w_s_fire && r_load_ch == CH_W'(i)) begin
                     w_wr_ptr_nxt[i] = r_wr_ptr[i] + PTR_W'(1);
                     if (s_axis_tlast || r_wr_ptr[i] == PTR_W'(DEPTH - 1)) begin
                        w_len_nxt[i]   = LEN_W'(r_wr_ptr[i]) + LEN_W'(1);
                        w_state_nxt[i] = S_ARMED;
                     end
                  end
               end
               S_PLAY: begin
                  if (m_axis_tready[i]) begin
                     if (LEN_W'(r_rd_ptr[i]) == r_len[i] - LEN_W'(1)) begin
                        w_rd_ptr_nxt[i] = '0;
                        if (!w_loop) w_state_nxt[i] = S_ARMED;
                     end else begin
                        w_rd_ptr_nxt[i] = r_rd_ptr[i] + PTR_W'(1);
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Stream handshakes are masked by rst so an abort takes effect in the reset cycle itself.
   always_comb begin
      w_load_ch_in_load = 1'b0;
      w_m_valid         = '0;
      m_axis_tdata      = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_load_ch == CH_W'(i) && r_state[i] == S_LOAD) w_load_ch_in_load = 1'b1;
         w_m_valid[i] = ~rst & (r_state[i] == S_PLAY);
         if (w_m_valid[i]) m_axis_tdata[i*DATA_W +: DATA_W] = r_mem[i][r_rd_ptr[i]];
      end
      s_axis_tready = ~rst & w_load_ch_in_load & ~load_start;
   end

   assign m_axis_tvalid = w_m_valid;
   assign ch_armed      = r_ch_armed;
   assign ch_busy       = r_ch_busy;

endmodule
